// File: rtl/regdst_pipe_sel.sv
// regdst_pipe_sel: write-register destination selector with a DEPTH-stage
// destination pipeline feeding the register-file write port.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   in_valid_i, reg_write_i    decode-stage valid and register-write control
//   reg_dst_i                  00=rt 01=rd 10=LINK_REG 11=no destination
//   rt_i, rd_i                 instruction register fields
//   stall_i                    hold every stage
//   flush_i                    kill the entry written into stage 0
//   rs_q_i, rt_q_i             source addresses queried for hazards
//   wb_addr_o, wb_en_o         registered write-back address / enable
//   hit_rs_o, hit_rt_o         query matches a live in-flight destination
//   hit_rs_stage_o, hit_rt_stage_o  youngest matching stage index
//
// Build option
//   REGDST_HAZARD_EN  compiles in the hazard compare; when undefined the hit
//                     outputs are tied to zero and no compare logic exists.

module regdst_pipe_sel #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  input  logic          reg_write_i,
  input  logic [1:0]    reg_dst_i,
  input  logic [AW-1:0] rt_i,
  input  logic [AW-1:0] rd_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [AW-1:0] rs_q_i,
  input  logic [AW-1:0] rt_q_i,
  output logic [AW-1:0] wb_addr_o,
  output logic          wb_en_o,
  output logic          hit_rs_o,
  output logic          hit_rt_o,
  output logic [1:0]    hit_rs_stage_o,
  output logic [1:0]    hit_rt_stage_o
);

  localparam int unsigned SW = 2;

  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]         live_q, live_d;
  logic [AW-1:0]            sel_c;
  logic                     sel_live_c;

  // Destination select in decode.
  always_comb begin
    sel_c = '0;
    case (reg_dst_i)
      2'b00:   sel_c = rt_i;
      2'b01:   sel_c = rd_i;
      2'b10:   sel_c = AW'(LINK_REG);
      default: sel_c = '0;
    endcase
  end

  // Writes to register 0 are architecturally discarded, so never live.
  assign sel_live_c = in_valid_i & reg_write_i & (reg_dst_i != 2'b11) & (sel_c != '0);

  // Stage advance; flush kills stage 0 even while the rest is stalled.
  always_comb begin
    addr_d = addr_q;
    live_d = live_q;
    if (!stall_i) begin
      addr_d[0] = sel_c;
      live_d[0] = sel_live_c;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        addr_d[i] = addr_q[i-1];
        live_d[i] = live_q[i-1];
      end
    end
    if (flush_i) begin
      live_d[0] = 1'b0;
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      live_q <= '0;
    end else begin
      addr_q <= addr_d;
      live_q <= live_d;
    end
  end

  // The last stage register is the write-back port.
  assign wb_addr_o = addr_q[DEPTH-1];
  assign wb_en_o   = live_q[DEPTH-1];

`ifdef REGDST_HAZARD_EN
  // Scan oldest to youngest so the youngest producer overwrites the result.
  // The WB stage is excluded: the register file writes in the first half.
  always_comb begin
    hit_rs_o       = 1'b0;
    hit_rt_o       = 1'b0;
    hit_rs_stage_o = '0;
    hit_rt_stage_o = '0;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      if (live_q[i] && (addr_q[i] == rs_q_i) && (rs_q_i != '0)) begin
        hit_rs_o       = 1'b1;
        hit_rs_stage_o = SW'(i);
      end
      if (live_q[i] && (addr_q[i] == rt_q_i) && (rt_q_i != '0)) begin
        hit_rt_o       = 1'b1;
        hit_rt_stage_o = SW'(i);
      end
    end
  end
`else
  logic unused_query_c;
  assign unused_query_c = ^{rs_q_i, rt_q_i};

  assign hit_rs_o       = 1'b0;
  assign hit_rt_o       = 1'b0;
  assign hit_rs_stage_o = SW'(0);
  assign hit_rt_stage_o = SW'(0);
`endif

endmodule
